// File: rtl/uart_pattern_detector_if.sv
// Byte-stream, pattern-load and display-control signals of the UART pattern detector.
// The master is the RX/config side; the slave is the detector.
interface uart_pattern_detector_if #(
  parameter int unsigned MAX_LEN = 8
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 pat_load;
  logic [4:0]           pat_len;
  logic [8*MAX_LEN-1:0] pat_data;
  logic                 match;
  logic                 show_active;
  logic                 blink_on;
  logic [15:0]          match_count;

  modport master (
    output rx_data, rx_valid, pat_load, pat_len, pat_data,
    input  match, show_active, blink_on, match_count
  );

  modport slave (
    input  rx_data, rx_valid, pat_load, pat_len, pat_data,
    output match, show_active, blink_on, match_count
  );
endinterface

// File: rtl/uart_pattern_detector.sv
// Streaming byte-pattern detector with overlapping matches, optional case folding,
// a timed blink window after each hit and a saturating hit counter.
//
// state | meaning
// IDLE  | pattern length is 0, nothing can match
// ARMED | searching the byte stream
// SHOW  | display window running, blink_on toggling
module uart_pattern_detector #(
  parameter int unsigned          MAX_LEN   = 8,
  parameter int unsigned          CLK_HZ    = 50_000_000,
  parameter int unsigned          SHOW_MS   = 3000,
  parameter int unsigned          BLINK_MS  = 500,
  parameter bit                   CASE_FOLD = 1'b1,
  parameter bit                   RETRIGGER = 1'b1,
  parameter int unsigned          INIT_LEN  = 5,
  // "hello" with byte 0 = 'h' in bits [7:0]
  parameter logic [8*MAX_LEN-1:0] INIT_PAT  = (8*MAX_LEN)'(40'h6f_6c_6c_65_68)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  uart_pattern_detector_if.slave   bus_if
);

  localparam int unsigned SHOW_CYC  = CLK_HZ / 1000 * SHOW_MS;
  localparam int unsigned BLINK_CYC = CLK_HZ / 1000 * BLINK_MS;
  localparam int unsigned SHOW_W    = $clog2(SHOW_CYC + 1);
  localparam int unsigned BLINK_W   = $clog2(BLINK_CYC + 1);
  localparam logic [4:0]  INIT_LEN_C = (INIT_LEN > MAX_LEN) ? 5'(MAX_LEN) : 5'(INIT_LEN);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;

  state_t               state_q;
  logic [4:0]           len_q;
  logic [8*MAX_LEN-1:0] pat_q;
  logic [8*MAX_LEN-1:0] hist_q;
  logic [4:0]           fill_q;
  logic [SHOW_W-1:0]    show_cnt_q;
  logic [BLINK_W-1:0]   blink_cnt_q;
  logic                 blink_q;
  logic                 show_q;
  logic                 match_q;
  logic [15:0]          count_q;

  logic [8*MAX_LEN-1:0] win;
  logic                 hit;
  logic [4:0]           len_d;
  logic [15:0]          count_d;

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (CASE_FOLD && (b >= 8'h41) && (b <= 8'h5A)) return b | 8'h20;
    return b;
  endfunction

  // win byte o is the o-th newest byte including the incoming one; it must equal
  // pattern byte len-1-o so the last pattern character lines up with the new byte.
  always_comb begin
    win     = {hist_q[8*MAX_LEN-9:0], bus_if.rx_data};
    hit     = bus_if.rx_valid && (len_q != 5'd0) && ((fill_q + 5'd1) >= len_q);
    for (int o = 0; o < int'(MAX_LEN); o++) begin
      if (o < int'(len_q)) begin
        if (fold(win[8*o +: 8]) != fold(pat_q[8*(int'(len_q) - 1 - o) +: 8])) hit = 1'b0;
      end
    end
    len_d   = (bus_if.pat_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : bus_if.pat_len;
    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= (INIT_LEN_C != 5'd0) ? ARMED : IDLE;
      len_q       <= INIT_LEN_C;
      pat_q       <= INIT_PAT;
      hist_q      <= '0;
      fill_q      <= '0;
      show_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      show_q      <= 1'b0;
      match_q     <= 1'b0;
      count_q     <= '0;
    end else if (bus_if.pat_load) begin
      // a byte strobed together with the load is dropped
      len_q       <= len_d;
      pat_q       <= bus_if.pat_data;
      hist_q      <= '0;
      fill_q      <= '0;
      state_q     <= (len_d != 5'd0) ? ARMED : IDLE;
      show_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      show_q      <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      match_q <= hit;
      if (hit) count_q <= count_d;
      if (bus_if.rx_valid) begin
        hist_q <= {hist_q[8*MAX_LEN-9:0], bus_if.rx_data};
        if (fill_q != 5'(MAX_LEN)) fill_q <= fill_q + 5'd1;
      end
      case (state_q)
        IDLE: begin
        end
        ARMED: begin
          if (hit) begin
            state_q     <= SHOW;
            show_q      <= 1'b1;
            blink_q     <= 1'b1;
            show_cnt_q  <= '0;
            blink_cnt_q <= '0;
          end
        end
        SHOW: begin
          if (hit && RETRIGGER) begin
            show_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
          end else if (show_cnt_q == SHOW_W'(SHOW_CYC - 1)) begin
            state_q <= ARMED;
            show_q  <= 1'b0;
            blink_q <= 1'b0;
          end else begin
            show_cnt_q <= show_cnt_q + 1'b1;
            if (blink_cnt_q == BLINK_W'(BLINK_CYC - 1)) begin
              blink_cnt_q <= '0;
              blink_q     <= ~blink_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.match       = match_q;
  assign bus_if.show_active = show_q;
  assign bus_if.blink_on    = blink_q;
  assign bus_if.match_count = count_q;

endmodule

// File: tb/tb_uart_pattern_detector.sv
// Bench for uart_pattern_detector: two instances (retrigger on/off) share one stimulus
// stream and are compared every cycle against a string/window-arithmetic reference.
module tb_uart_pattern_detector;
  localparam int SHOW_CYC  = 30;
  localparam int BLINK_CYC = 10;

  logic        clk = 1'b0;
  logic        drv_rst = 1'b1;
  logic        drv_v = 1'b0;
  logic [7:0]  drv_d = 8'h00;
  logic        drv_ld = 1'b0;
  logic [4:0]  drv_len = 5'd0;
  logic [63:0] drv_pd = 64'h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_pattern_detector_if #(.MAX_LEN(8)) bus_rt ();
  uart_pattern_detector_if #(.MAX_LEN(8)) bus_nr ();

  assign bus_rt.rx_data  = drv_d;
  assign bus_rt.rx_valid = drv_v;
  assign bus_rt.pat_load = drv_ld;
  assign bus_rt.pat_len  = drv_len;
  assign bus_rt.pat_data = drv_pd;
  assign bus_nr.rx_data  = drv_d;
  assign bus_nr.rx_valid = drv_v;
  assign bus_nr.pat_load = drv_ld;
  assign bus_nr.pat_len  = drv_len;
  assign bus_nr.pat_data = drv_pd;

  uart_pattern_detector #(
    .MAX_LEN(8), .CLK_HZ(10_000), .SHOW_MS(3), .BLINK_MS(1),
    .CASE_FOLD(1'b1), .RETRIGGER(1'b1)
  ) dut_rt (
    .clk_i(clk), .reset_i(drv_rst), .bus_if(bus_rt.slave)
  );

  uart_pattern_detector #(
    .MAX_LEN(8), .CLK_HZ(10_000), .SHOW_MS(3), .BLINK_MS(1),
    .CASE_FOLD(1'b1), .RETRIGGER(1'b0)
  ) dut_nr (
    .clk_i(clk), .reset_i(drv_rst), .bus_if(bus_nr.slave)
  );

  // reference state: byte history as a queue (newest first), pattern as a byte array,
  // display window as a start cycle per retrigger variant
  int          cyc = 0;
  byte unsigned hq[$];
  byte unsigned mpat[8];
  int          mlen;
  bit          m_match;
  int          m_count;
  bit          won[2];
  int          wstart[2];

  function automatic byte unsigned lc(input byte unsigned b);
    return (b >= 8'h41 && b <= 8'h5A) ? b + 8'd32 : b;
  endfunction

  function automatic bit in_win(input int r, input int c);
    return won[r] && (c >= wstart[r]) && (c < wstart[r] + SHOW_CYC);
  endfunction

  function automatic logic [63:0] mkpat(input string s);
    logic [63:0] p = 64'h0;
    for (int i = 0; i < s.len() && i < 8; i++) p[8*i +: 8] = s[i];
    return p;
  endfunction

  task automatic model_step();
    string init_s = "hello";
    bit    ok;
    cyc++;
    if (drv_rst) begin
      hq.delete();
      mlen = 5;
      for (int i = 0; i < 5; i++) mpat[i] = init_s[i];
      m_match = 0;
      m_count = 0;
      won[0] = 0;
      won[1] = 0;
    end else if (drv_ld) begin
      mlen = (drv_len > 5'd8) ? 8 : int'(drv_len);
      for (int i = 0; i < 8; i++) mpat[i] = drv_pd[8*i +: 8];
      hq.delete();
      m_match = 0;
      won[0] = 0;
      won[1] = 0;
    end else begin
      m_match = 0;
      if (drv_v) begin
        hq.push_front(drv_d);
        if (hq.size() > 8) void'(hq.pop_back());
        ok = (mlen > 0) && (hq.size() >= mlen);
        if (ok)
          for (int k = 0; k < mlen; k++)
            if (lc(hq[k]) != lc(mpat[mlen-1-k])) ok = 0;
        if (ok) begin
          m_match = 1;
          if (m_count < 65535) m_count++;
          for (int r = 0; r < 2; r++)
            if (r == 0 || !in_win(r, cyc - 1)) begin
              won[r]    = 1;
              wstart[r] = cyc;
            end
        end
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit sh;
    for (int r = 0; r < 2; r++) begin
      sh = in_win(r, cyc);
      if (r == 0) begin
        check_eq("rt_match", 32'(bus_rt.match), 32'(m_match));
        check_eq("rt_show", 32'(bus_rt.show_active), 32'(sh));
        check_eq("rt_blink", 32'(bus_rt.blink_on), 32'(sh && (((cyc - wstart[r]) / BLINK_CYC) % 2 == 0)));
        check_eq("rt_count", 32'(bus_rt.match_count), 32'(m_count));
      end else begin
        check_eq("nr_match", 32'(bus_nr.match), 32'(m_match));
        check_eq("nr_show", 32'(bus_nr.show_active), 32'(sh));
        check_eq("nr_blink", 32'(bus_nr.blink_on), 32'(sh && (((cyc - wstart[r]) / BLINK_CYC) % 2 == 0)));
        check_eq("nr_count", 32'(bus_nr.match_count), 32'(m_count));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drv_v  = 1'b0;
    drv_ld = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      drv_v = 1'b1;
      drv_d = s[i];
      tick();
    end
  endtask

  task automatic load(input int len, input logic [63:0] pd);
    drv_ld  = 1'b1;
    drv_len = 5'(len);
    drv_pd  = pd;
    tick();
  endtask

  initial begin
    string alpha = "aAbB";
    logic [63:0] rp;
    drv_rst = 1'b1;
    idle(2);
    drv_rst = 1'b0;
    idle(2);

    feed("xhello");
    idle(40);
    check_eq("xhello_count", 32'(bus_rt.match_count), 32'd1);

    load(4, mkpat("abab"));
    feed("ABaBab");
    idle(40);
    check_eq("abab_count", 32'(bus_rt.match_count), 32'd3);

    load(5, mkpat("hello"));
    feed("hello");
    idle(9);
    feed("hello");
    idle(50);

    drv_v = 1'b1;
    drv_d = "o";
    load(2, mkpat("ok"));
    feed("ok");
    idle(5);

    load(5, mkpat("hello"));
    feed("hello");
    idle(5);
    load(3, mkpat("abc"));
    idle(3);

    load(0, mkpat("hello"));
    for (int i = 0; i < 40; i++) begin
      drv_v = 1'($urandom_range(0, 1));
      drv_d = (i % 3 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      tick();
    end

    load(20, mkpat("abcdefgh"));
    feed("zabcdefgh");
    idle(35);

    load(3, 64'h0);
    drv_v = 1'b1; drv_d = 8'h00; tick();
    drv_v = 1'b1; drv_d = 8'h00; tick();
    drv_v = 1'b1; drv_d = 8'h00; tick();
    idle(35);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        for (int k = 0; k < 8; k++) rp[8*k +: 8] = alpha[$urandom_range(0, 3)];
        drv_ld  = 1'b1;
        drv_len = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 20)) : 5'($urandom_range(1, 4));
        drv_pd  = rp;
      end
      drv_v = ($urandom_range(0, 99) < 70);
      drv_d = alpha[$urandom_range(0, 3)];
      tick();
    end

    load(1, mkpat("a"));
    for (int i = 0; i < 65540; i++) begin
      drv_v = 1'b1;
      drv_d = (i % 2 == 0) ? "a" : "A";
      tick();
    end
    check_eq("sat_count", 32'(bus_rt.match_count), 32'hFFFF);
    check_eq("sat_show", 32'(bus_rt.show_active), 32'd1);

    drv_rst = 1'b1;
    tick();
    check_eq("rst_show", 32'(bus_rt.show_active), 32'd0);
    check_eq("rst_count", 32'(bus_rt.match_count), 32'd0);
    drv_rst = 1'b0;
    feed("hello");
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
